// File: rtl/flag_branch_unit_pkg.sv
// Shared CPU definitions: opcodes, flag bit positions, branch condition codes
// and the flag/branch FSM state type.
package flag_branch_unit_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_RED = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] NEQ    = 3'b000;
  localparam logic [2:0] EQ     = 3'b001;
  localparam logic [2:0] GT     = 3'b010;
  localparam logic [2:0] LT     = 3'b011;
  localparam logic [2:0] GTE    = 3'b100;
  localparam logic [2:0] LTE    = 3'b101;
  localparam logic [2:0] OVFL   = 3'b110;
  localparam logic [2:0] UNCOND = 3'b111;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

endpackage

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// Pure combinational evaluation of a 3-bit branch condition against {N,V,Z}.
module branch_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  // condition decode
  always_comb begin
    taken = 1'b0;
    case (cond)
      NEQ:     taken = ~flags[FLAG_Z];
      EQ:      taken = flags[FLAG_Z];
      GT:      taken = ~flags[FLAG_Z] & ~flags[FLAG_N];
      LT:      taken = flags[FLAG_N];
      GTE:     taken = flags[FLAG_Z] | ~flags[FLAG_N];
      LTE:     taken = flags[FLAG_N] | flags[FLAG_Z];
      OVFL:    taken = flags[FLAG_V];
      UNCOND:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register with EX->ID bypass, branch decision and a
// registered redirect pulse that also squashes the following ID slot.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [3:0] ex_opcode,
  input  logic [2:0] alu_flag,
  input  logic       ex_flush,
  input  logic       stall,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [2:0] id_cond,
  output logic [2:0] flags,
  output logic [2:0] eff_flags,
  output logic       branch_taken,
  output logic       redirect,
  output logic       id_squash
);

  logic [2:0] wm_s;
  logic [2:0] mask_s;
  logic       cond_true_s;
  logic       is_br_s;
  logic [2:0] flags_r;
  logic [2:0] flags_n_s;
  logic       redirect_r;
  logic       redirect_n_s;
  state_e     state_r;
  state_e     state_n_s;

  // opcode-dependent flag write mask, gated by a live unflushed EX slot
  always_comb begin
    wm_s = 3'b000;
    case (ex_opcode)
      OP_ADD, OP_SUB:                         wm_s = 3'b111;
      OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR: wm_s = 3'b001;
      default:                                wm_s = 3'b000;
    endcase
    if (ex_valid && !ex_flush) begin
      mask_s = wm_s;
    end else begin
      mask_s = 3'b000;
    end
  end

  // newest flags: fresh ALU bits where written, committed bits elsewhere
  assign eff_flags = (alu_flag & mask_s) | (flags_r & ~mask_s);

  branch_cond_eval u_cond (
    .cond  (id_cond),
    .flags (eff_flags),
    .taken (cond_true_s)
  );

  assign is_br_s      = (id_opcode == OP_B) | (id_opcode == OP_BR);
  assign branch_taken = id_valid & is_br_s & cond_true_s & (state_r == ST_RUN) & ~stall;

  // next-state, next-flags and next-redirect; a stall freezes everything
  always_comb begin
    state_n_s    = state_r;
    redirect_n_s = redirect_r;
    flags_n_s    = flags_r;
    if (!stall) begin
      flags_n_s = eff_flags;
      case (state_r)
        ST_RUN: begin
          if (branch_taken) begin
            state_n_s    = ST_SQUASH;
            redirect_n_s = 1'b1;
          end else begin
            state_n_s    = ST_RUN;
            redirect_n_s = 1'b0;
          end
        end
        ST_SQUASH: begin
          state_n_s    = ST_RUN;
          redirect_n_s = 1'b0;
        end
        default: begin
          state_n_s    = ST_RUN;
          redirect_n_s = 1'b0;
        end
      endcase
    end else begin
      state_n_s    = state_r;
      redirect_n_s = redirect_r;
    end
  end

  // state, flag and redirect registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RUN;
      redirect_r <= 1'b0;
      flags_r    <= 3'b000;
    end else begin
      state_r    <= state_n_s;
      redirect_r <= redirect_n_s;
      flags_r    <= flags_n_s;
    end
  end

  assign flags     = flags_r;
  assign redirect  = redirect_r;
  assign id_squash = (state_r == ST_SQUASH);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench: directed vector table, async reset check, full
// condition sweep and randomized traffic against a behavioural model.
module tb_flag_branch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid, ex_flush, stall, id_valid;
  logic [3:0] ex_opcode, id_opcode;
  logic [2:0] alu_flag, id_cond;
  logic [2:0] flags, eff_flags;
  logic       branch_taken, redirect, id_squash;

  int n_vec = 0;
  int n_bad = 0;

  // behavioural model state
  logic [2:0] m_flags;
  logic       m_redirect;
  logic       m_squash;
  logic [2:0] mask_tab [16];

  flag_branch_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_flag(alu_flag), .ex_flush(ex_flush), .stall(stall),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_cond(id_cond),
    .flags(flags), .eff_flags(eff_flags), .branch_taken(branch_taken),
    .redirect(redirect), .id_squash(id_squash)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ev;
    logic [3:0] eop;
    logic [2:0] alu;
    logic       fl;
    logic       st;
    logic       iv;
    logic [3:0] iop;
    logic [2:0] cc;
    logic [2:0] x_eff;
    logic       x_tk;
    logic [2:0] x_flags;
    logic       x_red;
    logic       x_sq;
  } vec_t;

  vec_t tab [15];

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic cond_holds(input logic [2:0] cc, input logic [2:0] f);
    bit n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (int'(cc))
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_comb(output logic [2:0] eff, output logic tk);
    logic [2:0] m;
    m = (ex_valid && !ex_flush) ? mask_tab[ex_opcode] : 3'b000;
    for (int b = 0; b < 3; b++) eff[b] = m[b] ? alu_flag[b] : m_flags[b];
    tk = id_valid && (id_opcode == 4'hC || id_opcode == 4'hD) &&
         cond_holds(id_cond, eff) && !m_squash && !stall;
  endtask

  task automatic model_commit(input logic [2:0] eff, input logic tk);
    if (!stall) begin
      m_flags = eff;
      if (m_squash) begin
        m_squash = 1'b0;
        m_redirect = 1'b0;
      end else begin
        m_squash = tk;
        m_redirect = tk;
      end
    end
  endtask

  task automatic model_reset();
    m_flags = 3'b000;
    m_redirect = 1'b0;
    m_squash = 1'b0;
  endtask

  // one cycle compared against the model; inputs already driven
  task automatic cycle_model(input string nm);
    logic [2:0] e;
    logic t;
    model_comb(e, t);
    #2;
    chk({nm, ".eff"}, eff_flags, e);
    chk({nm, ".taken"}, {2'b00, branch_taken}, {2'b00, t});
    @(posedge clk);
    model_commit(e, t);
    #1;
    chk({nm, ".flags"}, flags, m_flags);
    chk({nm, ".redirect"}, {2'b00, redirect}, {2'b00, m_redirect});
    chk({nm, ".squash"}, {2'b00, id_squash}, {2'b00, m_squash});
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_opcode = 4'h0; alu_flag = 3'b000; ex_flush = 1'b0;
    stall = 1'b0; id_valid = 1'b0; id_opcode = 4'h0; id_cond = 3'b000;
  endtask

  initial begin
    logic [2:0] e;
    logic t;
    for (int i = 0; i < 16; i++) mask_tab[i] = 3'b000;
    mask_tab[0] = 3'b111; mask_tab[1] = 3'b111;
    for (int i = 2; i <= 6; i++) mask_tab[i] = 3'b001;

    //            ev  eop    alu    fl    st    iv    iop    cc      eff    tk    flags  red   sq
    tab[0]  = '{1'b1, 4'h0, 3'b110, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000, 3'b110, 1'b0, 3'b110, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 4'h2, 3'b000, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000, 3'b110, 1'b0, 3'b110, 1'b0, 1'b0};
    tab[2]  = '{1'b1, 4'h2, 3'b001, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000, 3'b111, 1'b0, 3'b111, 1'b0, 1'b0};
    tab[3]  = '{1'b1, 4'h0, 3'b000, 1'b1, 1'b0, 1'b0, 4'h0, 3'b000, 3'b111, 1'b0, 3'b111, 1'b0, 1'b0};
    tab[4]  = '{1'b1, 4'h0, 3'b000, 1'b0, 1'b1, 1'b1, 4'hC, 3'b111, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0};
    tab[5]  = '{1'b1, 4'h1, 3'b000, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    tab[6]  = '{1'b1, 4'h1, 3'b001, 1'b0, 1'b0, 1'b1, 4'hC, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1};
    tab[7]  = '{1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 4'hC, 3'b111, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0};
    tab[8]  = '{1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 4'hD, 3'b111, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1};
    tab[9]  = '{1'b0, 4'h0, 3'b000, 1'b0, 1'b1, 1'b1, 4'hC, 3'b111, 3'b001, 1'b0, 3'b001, 1'b1, 1'b1};
    tab[10] = '{1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 4'hC, 3'b111, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0};
    tab[11] = '{1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 4'hC, 3'b011, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0};
    tab[12] = '{1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 4'h7, 3'b111, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0};
    tab[13] = '{1'b0, 4'h0, 3'b111, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0};
    tab[14] = '{1'b1, 4'h0, 3'b010, 1'b0, 1'b0, 1'b1, 4'hD, 3'b110, 3'b010, 1'b1, 3'b010, 1'b1, 1'b1};

    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.flags", flags, 3'b000);
    chk("reset.redirect", {2'b00, redirect}, 3'b000);
    chk("reset.squash", {2'b00, id_squash}, 3'b000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed table
    for (int i = 0; i < 15; i++) begin
      ex_valid = tab[i].ev; ex_opcode = tab[i].eop; alu_flag = tab[i].alu;
      ex_flush = tab[i].fl; stall = tab[i].st; id_valid = tab[i].iv;
      id_opcode = tab[i].iop; id_cond = tab[i].cc;
      model_comb(e, t);
      #2;
      chk($sformatf("vec%0d.eff", i), eff_flags, tab[i].x_eff);
      chk($sformatf("vec%0d.taken", i), {2'b00, branch_taken}, {2'b00, tab[i].x_tk});
      @(posedge clk);
      model_commit(e, t);
      #1;
      chk($sformatf("vec%0d.flags", i), flags, tab[i].x_flags);
      chk($sformatf("vec%0d.redirect", i), {2'b00, redirect}, {2'b00, tab[i].x_red});
      chk($sformatf("vec%0d.squash", i), {2'b00, id_squash}, {2'b00, tab[i].x_sq});
    end

    // async reset mid-cycle while in SQUASH with redirect high
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("async_rst.flags", flags, 3'b000);
    chk("async_rst.redirect", {2'b00, redirect}, 3'b000);
    chk("async_rst.squash", {2'b00, id_squash}, 3'b000);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    id_valid = 1'b1; id_opcode = 4'hC; id_cond = 3'b111;
    cycle_model("post_rst_run");

    // full condition sweep: every eff_flags value against every condition
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 8; c++) begin
        if (m_squash) begin
          idle_inputs();
          cycle_model("sweep_drain");
        end
        ex_valid = 1'b1; ex_opcode = 4'h0; alu_flag = 3'(f); ex_flush = 1'b0;
        stall = 1'b0; id_valid = 1'b1; id_opcode = (c[0]) ? 4'hD : 4'hC;
        id_cond = 3'(c);
        #2;
        chk($sformatf("sweep_f%0d_c%0d", f, c), {2'b00, branch_taken},
            {2'b00, cond_holds(3'(c), 3'(f))});
        #(-0);
        cycle_model($sformatf("sweep_f%0d_c%0d", f, c));
      end
    end

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      ex_valid  = 1'($urandom_range(0, 3) != 0);
      ex_opcode = 4'($urandom_range(0, 15));
      alu_flag  = 3'($urandom_range(0, 7));
      ex_flush  = 1'($urandom_range(0, 3) == 0);
      stall     = 1'($urandom_range(0, 3) == 0);
      id_valid  = 1'($urandom_range(0, 3) != 0);
      id_opcode = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15))
                                              : ((($urandom_range(0, 1)) == 0) ? 4'hC : 4'hD);
      id_cond   = 3'($urandom_range(0, 7));
      cycle_model($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
